// File: rtl/redmule_arb_pkg.sv
// Shared types and helpers for the RedMulE TCDM arbiter.
package redmule_arb_pkg;

  localparam int unsigned DefNReq = 2;
  localparam int unsigned DefAw   = 32;
  localparam int unsigned DefDw   = 32;

  // A single requester still needs one ID bit so that FIFO entries are never zero-width.
  function automatic int unsigned id_width(input int unsigned n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  localparam int unsigned DefIdW = id_width(DefNReq);

  typedef struct packed {
    logic [DefAw-1:0]   add;
    logic               wen;
    logic [DefDw/8-1:0] be;
    logic [DefDw-1:0]   data;
  } tcdm_req_t;

  typedef struct packed {
    logic [DefDw-1:0] r_data;
    logic             r_valid;
  } tcdm_rsp_t;

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions outstanding on the memory port.
module redmule_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM port among N_REQ requesters with in-order response routing.
// Optional per-requester grant/stall counters: define REDMULE_TCDM_ARB_PERF_EN.
module redmule_tcdm_arbiter
  import redmule_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic [N_REQ-1:0]        req_i,
  output logic [N_REQ-1:0]        gnt_o,
  input  logic [N_REQ*AW-1:0]     add_i,
  input  logic [N_REQ-1:0]        wen_i,
  input  logic [N_REQ*DW/8-1:0]   be_i,
  input  logic [N_REQ*DW-1:0]     data_i,
  output logic [DW-1:0]           r_data_o,
  output logic [N_REQ-1:0]        r_valid_o,
  output logic                    mst_req_o,
  input  logic                    mst_gnt_i,
  output logic [AW-1:0]           mst_add_o,
  output logic                    mst_wen_o,
  output logic [DW/8-1:0]         mst_be_o,
  output logic [DW-1:0]           mst_data_o,
  input  logic [DW-1:0]           mst_r_data_i,
  input  logic                    mst_r_valid_i,
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    err_o
`ifdef REDMULE_TCDM_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0]     perf_gnt_o,
  output logic [N_REQ*32-1:0]     perf_stall_o
`endif
);

  localparam int unsigned IdW = id_width(N_REQ);
  localparam int unsigned BeW = DW / 8;

  logic [IdW-1:0] rr_ptr_q, sel, head;
  logic           any_req, full, empty, handshake, pop, err_q;
  int unsigned    best;

  // Pick the requester with the smallest round-robin distance from rr_ptr.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    best    = N_REQ;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_i[i] && (((i + N_REQ - 32'(rr_ptr_q)) % N_REQ) < best)) begin
        best    = (i + N_REQ - 32'(rr_ptr_q)) % N_REQ;
        sel     = IdW'(i);
        any_req = 1'b1;
      end
    end
  end

  assign mst_req_o = any_req & ~full & ~rst_i;
  assign handshake = mst_req_o & mst_gnt_i;
  assign gnt_o     = handshake ? (N_REQ'(1) << sel) : '0;

  always_comb begin
    mst_add_o  = '0;
    mst_wen_o  = 1'b0;
    mst_be_o   = '0;
    mst_data_o = '0;
    if (mst_req_o) begin
      mst_add_o  = add_i[32'(sel)*AW +: AW];
      mst_wen_o  = wen_i[sel];
      mst_be_o   = be_i[32'(sel)*BeW +: BeW];
      mst_data_o = data_i[32'(sel)*DW +: DW];
    end
  end

  assign pop       = mst_r_valid_i & ~empty & ~rst_i;
  assign r_valid_o = pop ? (N_REQ'(1) << head) : '0;
  assign r_data_o  = mst_r_data_i;
  assign err_o     = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (handshake) rr_ptr_q <= (32'(sel) == N_REQ - 1) ? '0 : sel + IdW'(1);
      if (mst_r_valid_i && empty) err_q <= 1'b1;
    end
  end

  redmule_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

`ifdef REDMULE_TCDM_ARB_PERF_EN
  logic [31:0] perf_gnt_q   [N_REQ];
  logic [31:0] perf_stall_q [N_REQ];

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rst_i) begin
        perf_gnt_q[i]   <= '0;
        perf_stall_q[i] <= '0;
      end else begin
        if (gnt_o[i] && perf_gnt_q[i] != '1) perf_gnt_q[i] <= perf_gnt_q[i] + 32'd1;
        if (req_i[i] && !gnt_o[i] && perf_stall_q[i] != '1) begin
          perf_stall_q[i] <= perf_stall_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_gnt_o   = '0;
    perf_stall_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      perf_gnt_o[i*32 +: 32]   = perf_gnt_q[i];
      perf_stall_o[i*32 +: 32] = perf_stall_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a randomized reference-model run.
module tb_redmule_tcdm_arbiter;

  localparam int N_REQ = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAX_OUTST = 4;
  localparam logic [31:0] A0 = 32'h1C01_0000;
  localparam logic [31:0] A1 = 32'h1C02_0000;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_REQ-1:0]      req_i = '0, gnt_o, wen_i = '0, r_valid_o;
  logic [N_REQ*AW-1:0]   add_i = '0;
  logic [N_REQ*BW-1:0]   be_i = '0;
  logic [N_REQ*DW-1:0]   data_i = '0;
  logic [DW-1:0]         r_data_o, mst_data_o, mst_r_data_i = '0;
  logic                  mst_req_o, mst_gnt_i = 1'b0, mst_wen_o, mst_r_valid_i = 1'b0, err_o;
  logic [AW-1:0]         mst_add_o;
  logic [BW-1:0]         mst_be_o;
`ifdef REDMULE_TCDM_ARB_PERF_EN
  logic [N_REQ*32-1:0]   perf_gnt_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  redmule_tcdm_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i),
    .r_data_o(r_data_o), .r_valid_o(r_valid_o), .mst_req_o(mst_req_o), .mst_gnt_i(mst_gnt_i),
    .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o), .mst_be_o(mst_be_o), .mst_data_o(mst_data_o),
    .mst_r_data_i(mst_r_data_i), .mst_r_valid_i(mst_r_valid_i), .clk_i(clk), .rst_i(rst),
    .err_o(err_o)
`ifdef REDMULE_TCDM_ARB_PERF_EN
    , .perf_gnt_o(perf_gnt_o), .perf_stall_o(perf_stall_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]  req;
    logic        mg;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  egnt;
    logic        emreq;
    logic [31:0] eadd;
    logic        ewen;
    logic [1:0]  erv;
    logic        eerr;
  } vec_t;

  vec_t vt [14];

  logic [AW-1:0] f_add  [N_REQ];
  logic          f_wen  [N_REQ];
  logic [BW-1:0] f_be   [N_REQ];
  logic [DW-1:0] f_data [N_REQ];

  task automatic apply_fields();
    for (int i = 0; i < N_REQ; i++) begin
      add_i[i*AW +: AW]  = f_add[i];
      wen_i[i]           = f_wen[i];
      be_i[i*BW +: BW]   = f_be[i];
      data_i[i*DW +: DW] = f_data[i];
    end
  endtask

  task automatic drive(input logic [1:0] rq, input logic mg, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    req_i = rq; mst_gnt_i = mg; mst_r_valid_i = rv; mst_r_data_i = rd;
  endtask

  task automatic pulse_reset(input logic [1:0] hold_req);
    @(posedge clk);
    #1;
    rst = 1'b1; req_i = hold_req; mst_gnt_i = 1'b1; mst_r_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mst_req", 64'(mst_req_o), 64'd0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rvalid", 64'(r_valid_o), 64'd0);
  endtask

  // MAX_OUTST grants from an empty FIFO, then backpressure.
  task automatic fill_check(input string tag);
    for (int k = 0; k < MAX_OUTST; k++) begin
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk({tag, "_fill_gnt"}, 64'(gnt_o), 64'b01);
    end
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk({tag, "_full_req"}, 64'(mst_req_o), 64'd0);
    chk({tag, "_full_gnt"}, 64'(gnt_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int resp [N_REQ];
    logic [1:0] g_exp, g_prev;
    int q [$];
    int rr_m, sel_m, mem_cnt, pg [N_REQ], ps [N_REQ];
    bit err_m, found, hs, req_r [N_REQ];
    logic [1:0] eg, erv;

    f_add[0] = A0; f_wen[0] = 1'b1; f_be[0] = 4'hF; f_data[0] = 32'h0;
    f_add[1] = A1; f_wen[1] = 1'b0; f_be[1] = 4'h3; f_data[1] = 32'hCAFE_0001;
    apply_fields();

    //          req    mg    rv    rdata         egnt   emreq eadd   ewen  erv    eerr
    vt[0]  = '{2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0,    1'b1, 2'b00, 1'b0};
    vt[1]  = '{2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0};
    vt[2]  = '{2'b01, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, A0,    1'b1, 2'b00, 1'b0};
    vt[3]  = '{2'b01, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, A0,    1'b1, 2'b00, 1'b0};
    vt[4]  = '{2'b01, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, A0,    1'b1, 2'b00, 1'b0};
    vt[5]  = '{2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0,    1'b1, 2'b00, 1'b0};
    vt[6]  = '{2'b11, 1'b1, 1'b1, 32'h1111_1111, 2'b10, 1'b1, A1,   1'b0, 2'b01, 1'b0};
    vt[7]  = '{2'b01, 1'b1, 1'b1, 32'h2222_2222, 2'b01, 1'b1, A0,   1'b1, 2'b10, 1'b0};
    vt[8]  = '{2'b00, 1'b0, 1'b1, 32'h3333_3333, 2'b00, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0};
    vt[9]  = '{2'b00, 1'b0, 1'b1, 32'h4444_4444, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0};
    vt[10] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1};
    vt[11] = '{2'b10, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, A1,    1'b0, 2'b00, 1'b1};
    vt[12] = '{2'b00, 1'b0, 1'b1, 32'h5555_5555, 2'b00, 1'b0, 32'h0, 1'b0, 2'b10, 1'b1};
    vt[13] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1};

    pulse_reset(2'b01);

    for (int v = 0; v < 14; v++) begin
      drive(vt[v].req, vt[v].mg, vt[v].rv, vt[v].rd);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", v), 64'(gnt_o), 64'(vt[v].egnt));
      chk($sformatf("vec%0d_mst_req", v), 64'(mst_req_o), 64'(vt[v].emreq));
      chk($sformatf("vec%0d_mst_add", v), 64'(mst_add_o), 64'(vt[v].eadd));
      chk($sformatf("vec%0d_mst_wen", v), 64'(mst_wen_o), 64'(vt[v].ewen));
      chk($sformatf("vec%0d_r_valid", v), 64'(r_valid_o), 64'(vt[v].erv));
      chk($sformatf("vec%0d_err", v), 64'(err_o), 64'(vt[v].eerr));
      if (vt[v].erv != 2'b00) chk($sformatf("vec%0d_r_data", v), 64'(r_data_o), 64'(vt[v].rd));
    end

    // Fairness: both request continuously, responses one cycle behind.
    pulse_reset(2'b01);
    resp[0] = 0; resp[1] = 0; g_prev = 2'b00;
    for (int k = 0; k < 7; k++) begin
      drive((k < 6) ? 2'b11 : 2'b00, 1'b1, k > 0, 32'hA000_0000 + 32'(k));
      @(negedge clk);
      g_exp = (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fair%0d_gnt", k), 64'(gnt_o), 64'(g_exp));
      if (k > 0) chk($sformatf("fair%0d_r_valid", k), 64'(r_valid_o), 64'(g_prev));
      for (int i = 0; i < N_REQ; i++) if (r_valid_o[i]) resp[i]++;
      g_prev = g_exp;
    end
    chk("fair_resp0", 64'(resp[0]), 64'd3);
    chk("fair_resp1", 64'(resp[1]), 64'd3);
    chk("fair_err", 64'(err_o), 64'd0);
`ifdef REDMULE_TCDM_ARB_PERF_EN
    chk("perf_gnt0", 64'(perf_gnt_o[31:0]), 64'd3);
    chk("perf_gnt1", 64'(perf_gnt_o[63:32]), 64'd3);
    chk("perf_stall0", 64'(perf_stall_o[31:0]), 64'd3);
    chk("perf_stall1", 64'(perf_stall_o[63:32]), 64'd3);
`endif

    // Full backpressure: a pop on the full cycle must not fall through.
    pulse_reset(2'b00);
    fill_check("bp");
    drive(2'b01, 1'b1, 1'b1, 32'h0000_0055);
    @(negedge clk);
    chk("bp_pop_req", 64'(mst_req_o), 64'd0);
    chk("bp_pop_gnt", 64'(gnt_o), 64'd0);
    chk("bp_pop_rvalid", 64'(r_valid_o), 64'b01);
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("bp_regnt", 64'(gnt_o), 64'b01);

    // Reset while full discards the outstanding IDs.
    pulse_reset(2'b01);
    fill_check("rst_mid");

    // Randomized run against a queue-based reference model.
    pulse_reset(2'b00);
    rr_m = 0; err_m = 1'b0; mem_cnt = 0; q.delete();
    for (int i = 0; i < N_REQ; i++) begin req_r[i] = 1'b0; pg[i] = 0; ps[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) req_i[i] = req_r[i];
      apply_fields();
      mst_gnt_i     = ($urandom_range(0, 3) != 0);
      mst_r_valid_i = (mem_cnt > 0) && ($urandom_range(0, 1) == 1);
      mst_r_data_i  = $urandom;
      @(negedge clk);
      found = 1'b0; sel_m = 0;
      for (int d = 0; d < N_REQ; d++) begin
        if (!found && req_r[(rr_m + d) % N_REQ]) begin sel_m = (rr_m + d) % N_REQ; found = 1'b1; end
      end
      hs  = found && (q.size() < MAX_OUTST) && mst_gnt_i;
      eg  = '0;
      if (hs) eg[sel_m] = 1'b1;
      erv = '0;
      if (mst_r_valid_i && q.size() > 0) erv[q[0]] = 1'b1;
      chk("rnd_mst_req", 64'(mst_req_o), 64'(found && (q.size() < MAX_OUTST)));
      chk("rnd_gnt", 64'(gnt_o), 64'(eg));
      chk("rnd_r_valid", 64'(r_valid_o), 64'(erv));
      chk("rnd_err", 64'(err_o), 64'(err_m));
      if (found && q.size() < MAX_OUTST) begin
        chk("rnd_mst_add", 64'(mst_add_o), 64'(f_add[sel_m]));
        chk("rnd_mst_wen", 64'(mst_wen_o), 64'(f_wen[sel_m]));
        chk("rnd_mst_be", 64'(mst_be_o), 64'(f_be[sel_m]));
        chk("rnd_mst_data", 64'(mst_data_o), 64'(f_data[sel_m]));
      end
      if (erv != '0) chk("rnd_r_data", 64'(r_data_o), 64'(mst_r_data_i));
      for (int i = 0; i < N_REQ; i++) begin
        if (eg[i]) pg[i]++;
        else if (req_r[i]) ps[i]++;
      end
      if (mst_r_valid_i) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
        mem_cnt--;
      end
      if (hs) begin
        q.push_back(sel_m);
        rr_m = (sel_m + 1) % N_REQ;
        req_r[sel_m] = 1'b0;
        mem_cnt++;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_r[i] && $urandom_range(0, 1) == 1) begin
          req_r[i] = 1'b1;
          f_add[i] = $urandom; f_wen[i] = 1'($urandom); f_be[i] = 4'($urandom); f_data[i] = $urandom;
        end
      end
    end
`ifdef REDMULE_TCDM_ARB_PERF_EN
    for (int i = 0; i < N_REQ; i++) begin
      chk($sformatf("rnd_perf_gnt%0d", i), 64'(perf_gnt_o[i*32 +: 32]), 64'(pg[i]));
      chk($sformatf("rnd_perf_stall%0d", i), 64'(perf_stall_o[i*32 +: 32]), 64'(ps[i]));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
